a_unlock: RTL and testbench
===========================

# a_unlock

Entry stage that gates the LED countdown. It debounces the five Basys3 pushbuttons and checks them against a four-press unlock code. Once the full code has been entered it raises `a_done` and holds it as a steady level, which the countdown stage downstream consumes. It also reports progress and failed attempts for display on the seven-segment and LED logic.

## Interface
Parameters:
- `TICK_DIV`, default 250000: CLOCK cycles per debounce sample tick (400 Hz at 100 MHz); legal range ≥ 2.
- `DEB_CYCLES`, default 4: consecutive identical samples needed to accept a new button level; legal range 1..15.
- `CODE`, default {3'd1,3'd2,3'd3,3'd4}: four 3-bit button indices; step 0 is in `[11:9]` and step 3 is in `[2:0]`. Each index must be 0..4.
- `MAX_FAIL`, default 3: consecutive wrong presses that trigger lockout (only used with `A_UNLOCK_LOCKOUT_EN`).
- `LOCK_TICKS`, default 1200: lockout length in sample ticks (only used with `A_UNLOCK_LOCKOUT_EN`).

Ports (clock and reset first):
- `CLOCK`, in, 1: system clock; every flop is clocked on its rising edge.
- `RESETN`, in, 1: asynchronous, active-low reset.
- `btn`, in, 5: raw, asynchronous pushbuttons, ordered {D,R,L,U,C} = indices 4..0.
- `a_done`, out, 1: code accepted; held high until reset.
- `step`, out, 3: number of correct presses so far, 0..4.
- `fail_cnt`, out, 4: total wrong presses; saturates at 15.
- `locked`, out, 1: high while in lockout.

## Operation
- **Input synchronisation:** each `btn` bit passes through a 2-flop synchroniser.
- **Sample tick:** a free-running counter counts 0..TICK_DIV-1 and emits a one-cycle `tick` when it wraps.
- **Debounce (per button):**
  - On each `tick`, if the synchronised level differs from the debounced level, increment that button's counter; otherwise clear it.
  - When the counter reaches `DEB_CYCLES`, update the debounced level and clear the counter.
- **Press pulse:** `press[i]` is a one-cycle pulse on a 0→1 transition of debounced bit i.
- **Press evaluation:** while the FSM is in S0..S3, a cycle with any `press` bit set counts as one press event.
  - **Correct press:** exactly one bit is set and its index equals `CODE[step]`. The FSM advances one state and the consecutive-fail counter clears.
  - **Wrong press:** anything else, including two or more bits set together. The FSM returns to S0, `fail_cnt` increments (saturating) and the consecutive-fail counter increments.
  - A wrong press in S0 still counts as a fail.
- **FSM states:**
  - S0, S1, S2, S3: `step` = 0..3.
  - DONE: `step` = 4 and `a_done` = 1. DONE is absorbing, and all presses are ignored.
  - LOCK: only exists with the macro compiled in; see Configuration.
- **Reset values:** `a_done`=0, `step`=0, `fail_cnt`=0, `locked`=0. The FSM is in S0 and all counters, debounced levels and synchroniser flops are 0.
- **Reset during operation:** takes effect immediately, whatever the state, including DONE and LOCK.

## Timing
- **`btn` edge to accepted level:** 2 synchroniser cycles, then `DEB_CYCLES` ticks. Worst case is 2 + DEB_CYCLES×TICK_DIV cycles.
- **Press pulse:** `press` is high for exactly 1 cycle, in the cycle after the debounced level changes.
- **State and outputs:** the state register updates on the edge that samples `press`. `step`, `a_done`, `fail_cnt` and `locked` are registered and valid 1 cycle after the press pulse.
- **Bounce:** a glitch shorter than `DEB_CYCLES` ticks produces no pulse.
- **Release:** releasing a button never generates an event.
- **Downstream handoff:** `a_done` is a level with no handshake. The downstream stage may sample it in any clock domain derived from CLOCK.

## Configuration
- **Macro:** `A_UNLOCK_LOCKOUT_EN`.
- **When defined:**
  - When the consecutive-fail count reaches `MAX_FAIL`, the FSM enters LOCK: `locked`=1, `step`=0, and presses are ignored and not counted.
  - LOCK lasts exactly `LOCK_TICKS` ticks, counted from the first tick after entry.
  - On exit the FSM goes to S0, the consecutive-fail count clears and `locked`=0.
- **When undefined:** there is no LOCK state, `locked` is tied to 0, and `MAX_FAIL` and `LOCK_TICKS` are unused.

## Test plan
Sim parameters: TICK_DIV=4, DEB_CYCLES=3.
1. **Reset:** reset asserted then released → all outputs 0. Any mid-sequence reset (at `step`=2) → `step`=0 on the same edge and `a_done`=0.
2. **Correct code:** clean presses U, L, R, D, each held for 20 cycles → `step` goes 1, 2, 3, 4; `a_done`=1 and it stays 1 through 5 further presses.
3. **Bounce:** U toggling every 2 cycles for 30 cycles, then held → exactly one press event and `step`=1.
4. **Wrong press:** U, L, then C → `step`=0 and `fail_cnt`=1. Pressing L and R simultaneously in S0 → `fail_cnt`=2.
5. **Lockout (macro defined):** 3 wrong presses → `locked`=1; a correct U during lock leaves `step`=0. After 1200 ticks, `locked`=0 and U gives `step`=1. With the macro undefined, the same stimulus leaves `locked`=0 throughout.
6. **Saturation:** 20 wrong presses with the macro undefined → `fail_cnt`=15.

Source files
------------

// File: rtl/a_unlock_if.sv
// a_unlock_if: groups the pushbutton input and the unlock status outputs of a_unlock.
//   btn      : raw pushbuttons {D,R,L,U,C} (indices 4..0)
//   a_done   : code accepted, held until reset
//   step     : correct presses so far, 0..4
//   fail_cnt : total wrong presses, saturating at 15
//   locked   : high while in lockout
// master drives btn (board/bench side); slave is the a_unlock side.
interface a_unlock_if;
  logic [4:0] btn;
  logic       a_done;
  logic [2:0] step;
  logic [3:0] fail_cnt;
  logic       locked;

  modport master (
    output btn,
    input  a_done,
    input  step,
    input  fail_cnt,
    input  locked
  );

  modport slave (
    input  btn,
    output a_done,
    output step,
    output fail_cnt,
    output locked
  );
endinterface

// File: rtl/a_unlock.sv
// a_unlock: debounces the five pushbuttons and checks them against a four-press unlock code.
// Once the code is entered, a_done rises and stays high until reset.
// Ports:
//   CLOCK  : system clock, rising edge
//   RESETN : asynchronous active-low reset
//   bus    : a_unlock_if.slave (btn in; a_done, step, fail_cnt, locked out)
// Optional feature: define A_UNLOCK_LOCKOUT_EN to enable the lockout state after MAX_FAIL
// consecutive wrong presses (lasts LOCK_TICKS sample ticks). Otherwise locked is tied to 0.
module a_unlock #(
  parameter int unsigned TICK_DIV   = 250000,
  parameter int unsigned DEB_CYCLES = 4,
  parameter logic [11:0] CODE       = {3'd1, 3'd2, 3'd3, 3'd4},
  parameter int unsigned MAX_FAIL   = 3,
  parameter int unsigned LOCK_TICKS = 1200
) (
  input logic       CLOCK,
  input logic       RESETN,
  a_unlock_if.slave bus
);

  localparam int unsigned TickW = $clog2(TICK_DIV);

  if (TICK_DIV < 2 || DEB_CYCLES < 1 || DEB_CYCLES > 15 || MAX_FAIL < 1 || LOCK_TICKS < 1 ||
      CODE[11:9] > 3'd4 || CODE[8:6] > 3'd4 || CODE[5:3] > 3'd4 || CODE[2:0] > 3'd4)
  begin : g_param_err
    $error("a_unlock: illegal parameter value");
  end

`ifdef A_UNLOCK_LOCKOUT_EN
  localparam int unsigned LockW = $clog2(LOCK_TICKS + 1);
  typedef enum logic [2:0] {StS0, StS1, StS2, StS3, StDone, StLock} state_e;
`else
  typedef enum logic [2:0] {StS0, StS1, StS2, StS3, StDone} state_e;
`endif

  logic [4:0]       sync1_q, sync2_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [4:0]       deb_q, deb_d, deb_dly_q;
  logic [4:0][3:0]  deb_cnt_q, deb_cnt_d;
  logic [4:0]       press;
  state_e           state_q, state_d;
  logic [3:0]       fail_q, fail_d;
  logic [2:0]       code_idx;
  logic             hit;
`ifdef A_UNLOCK_LOCKOUT_EN
  logic [3:0]       consec_q, consec_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  assign tick  = (tick_cnt_q == TickW'(TICK_DIV - 1));
  // deb_dly_q lags deb_q by one cycle, so a rising level yields exactly one pulse cycle.
  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (tick) begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] + 4'd1 == 4'(DEB_CYCLES)) begin
            deb_d[i]     = sync2_q[i];
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    unique case (state_q[1:0])
      2'd0:    code_idx = CODE[11:9];
      2'd1:    code_idx = CODE[8:6];
      2'd2:    code_idx = CODE[5:3];
      default: code_idx = CODE[2:0];
    endcase
  end

  // A single set bit matching the expected index; multi-bit presses never match.
  assign hit = (press == (5'b00001 << code_idx));

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
`ifdef A_UNLOCK_LOCKOUT_EN
    consec_d   = consec_q;
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      StS0, StS1, StS2, StS3: begin
        if (|press) begin
          if (hit) begin
            state_d = state_e'(state_q + 3'd1);
`ifdef A_UNLOCK_LOCKOUT_EN
            consec_d = '0;
`endif
          end else begin
            state_d = StS0;
            if (fail_q != 4'hf) fail_d = fail_q + 4'd1;
`ifdef A_UNLOCK_LOCKOUT_EN
            if (consec_q != 4'hf) consec_d = consec_q + 4'd1;
            if (32'(consec_q) + 32'd1 >= MAX_FAIL) begin
              state_d    = StLock;
              lock_cnt_d = '0;
            end
`endif
          end
        end
      end
      StDone: ;
`ifdef A_UNLOCK_LOCKOUT_EN
      StLock: begin
        if (tick) begin
          if (lock_cnt_q == LockW'(LOCK_TICKS - 1)) begin
            state_d    = StS0;
            consec_d   = '0;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = StS0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      deb_cnt_q  <= '0;
      state_q    <= StS0;
      fail_q     <= '0;
`ifdef A_UNLOCK_LOCKOUT_EN
      consec_q   <= '0;
      lock_cnt_q <= '0;
`endif
    end else begin
      sync1_q    <= bus.btn;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      fail_q     <= fail_d;
`ifdef A_UNLOCK_LOCKOUT_EN
      consec_q   <= consec_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Outputs are decodes of registered state only.
  always_comb begin
    bus.a_done   = (state_q == StDone);
    bus.fail_cnt = fail_q;
    bus.locked   = 1'b0;
    bus.step     = 3'd0;
    case (state_q)
      StS0, StS1, StS2, StS3: bus.step = {1'b0, state_q[1:0]};
      StDone:                 bus.step = 3'd4;
      default:                bus.step = 3'd0;
    endcase
`ifdef A_UNLOCK_LOCKOUT_EN
    bus.locked = (state_q == StLock);
`endif
  end

endmodule

// File: tb/tb_a_unlock.sv
// tb_a_unlock: directed and randomized checks of a_unlock with TICK_DIV=4, DEB_CYCLES=3.
// The reference model works at press-event level: each clean press advances or resets the
// expected code progress and failure count.
module tb_a_unlock;

  localparam logic [4:0] BtnC = 5'b00001;
  localparam logic [4:0] BtnU = 5'b00010;
  localparam logic [4:0] BtnL = 5'b00100;
  localparam logic [4:0] BtnR = 5'b01000;
  localparam logic [4:0] BtnD = 5'b10000;

  bit   clk;
  logic rstn;
  int   total;
  int   bad;

  // Expected-state model
  int m_step;
  int m_fail;
  int m_consec;
  bit m_done;
  int code[4] = '{1, 2, 3, 4};

  a_unlock_if bus ();

  a_unlock #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .CLOCK (clk),
    .RESETN(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_step   = 0;
    m_fail   = 0;
    m_consec = 0;
    m_done   = 0;
  endtask

  task automatic model_press(input logic [4:0] mask);
    logic [4:0] want;
    if (m_done) return;
    want = 5'b00001 << code[m_step];
    if (mask == want) begin
      m_step++;
      m_consec = 0;
      if (m_step == 4) m_done = 1;
    end else begin
      m_step = 0;
      m_consec++;
      if (m_fail < 15) m_fail++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Clean press: hold, then release long enough for the release to debounce too.
  task automatic do_press(input logic [4:0] mask, input int hold);
    @(negedge clk);
    bus.btn = mask;
    repeat (hold) @(negedge clk);
    bus.btn = 5'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic press_and_check(input string tag, input logic [4:0] mask, input int hold);
    do_press(mask, hold);
    model_press(mask);
    check({tag, ".step"}, 32'(bus.step), 32'(m_done ? 4 : m_step));
    check({tag, ".fail"}, 32'(bus.fail_cnt), 32'(m_fail));
    check({tag, ".done"}, 32'(bus.a_done), 32'(m_done));
    check({tag, ".locked"}, 32'(bus.locked), 32'd0);
  endtask

  initial begin
    logic [4:0] mask;
    int a;
    int b;
    int sel;
    total   = 0;
    bad     = 0;
    rstn    = 1'b0;
    bus.btn = 5'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst.done", 32'(bus.a_done), 32'd0);
    check("rst.step", 32'(bus.step), 32'd0);
    check("rst.fail", 32'(bus.fail_cnt), 32'd0);
    check("rst.locked", 32'(bus.locked), 32'd0);

    // Mid-sequence asynchronous reset at step 2
    press_and_check("mid.u", BtnU, 20);
    press_and_check("mid.l", BtnL, 20);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst.step", 32'(bus.step), 32'd0);
    check("midrst.done", 32'(bus.a_done), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);

    // Correct code, then DONE is absorbing
    press_and_check("code.u", BtnU, 20);
    press_and_check("code.l", BtnL, 20);
    press_and_check("code.r", BtnR, 20);
    press_and_check("code.d", BtnD, 20);
    check("code.done_hi", 32'(bus.a_done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      mask = 5'b00001 << $urandom_range(0, 4);
      press_and_check("done.hold", mask, 20);
    end

    // Bounce on U followed by a steady hold
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.btn = (i % 2 == 0) ? BtnU : 5'b0;
      repeat (2) @(negedge clk);
    end
    bus.btn = BtnU;
    repeat (20) @(negedge clk);
    bus.btn = 5'b0;
    repeat (20) @(negedge clk);
    model_press(BtnU);
    check("bounce.step", 32'(bus.step), 32'd1);
    check("bounce.fail", 32'(bus.fail_cnt), 32'd0);

    // Wrong presses: U, L, C then simultaneous L+R
    press_and_check("wrong.l", BtnL, 20);
    press_and_check("wrong.c", BtnC, 20);
    check("wrong.c_fail1", 32'(bus.fail_cnt), 32'd1);
    press_and_check("wrong.lr", BtnL | BtnR, 20);
    check("wrong.lr_fail2", 32'(bus.fail_cnt), 32'd2);

    // Randomized presses against the model; never three consecutive fails
    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 99);
      if (m_done) begin
        do_reset();
      end
      if (m_consec >= 2 || sel < 60) begin
        mask = 5'b00001 << code[m_step];
      end else if (sel < 85) begin
        mask = 5'b00001 << $urandom_range(0, 4);
      end else begin
        a    = $urandom_range(0, 4);
        b    = (a + 1 + $urandom_range(0, 3)) % 5;
        mask = (5'b00001 << a) | (5'b00001 << b);
      end
      press_and_check("rand", mask, 20 + $urandom_range(0, 10));
    end

    do_reset();
`ifdef A_UNLOCK_LOCKOUT_EN
    // Lockout after three wrong presses
    for (int i = 0; i < 3; i++) do_press(BtnC, 20);
    check("lock.entered", 32'(bus.locked), 32'd1);
    check("lock.fail", 32'(bus.fail_cnt), 32'd3);
    do_press(BtnU, 20);
    check("lock.ignore_step", 32'(bus.step), 32'd0);
    check("lock.ignore_fail", 32'(bus.fail_cnt), 32'd3);
    repeat (4200) @(negedge clk);
    check("lock.still", 32'(bus.locked), 32'd1);
    begin
      int waited;
      waited = 0;
      while (bus.locked === 1'b1 && waited < 800) begin
        @(negedge clk);
        waited++;
      end
    end
    check("lock.exit", 32'(bus.locked), 32'd0);
    do_press(BtnU, 20);
    check("lock.after_u", 32'(bus.step), 32'd1);
`else
    // Without lockout: same stimulus never locks, and fail_cnt saturates
    for (int i = 0; i < 3; i++) press_and_check("nolock", BtnC, 20);
    do_press(BtnU, 20);
    model_press(BtnU);
    check("nolock.u_step", 32'(bus.step), 32'd1);
    check("nolock.locked", 32'(bus.locked), 32'd0);
    do_reset();
    for (int i = 0; i < 20; i++) press_and_check("sat", BtnC, 20);
    check("sat.fail15", 32'(bus.fail_cnt), 32'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
